// File: rtl/seq_index_tracker.sv
// seq_index_tracker: recovers index and count direction from a mod-11 Fibonacci/prime term stream.
// Outputs registered one edge after sampling; no backpressure, en qualifies each sample.
module seq_index_tracker #(
    parameter int ERR_W = 4,
    parameter int MOD   = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             fibPri,
    input  logic [5:0]       value,
    output logic [3:0]       index,
    output logic             dir,
    output logic             locked,
    output logic             err,
    output logic             dir_chg,
    output logic [ERR_W-1:0] err_count
);
    typedef enum logic [1:0] {IDLE, ACQ, LOCKED} state_t;

    localparam logic [3:0] LAST = 4'(MOD - 1);

    function automatic logic [5:0] term(input logic sel, input logic [3:0] i);
        case (i)
            4'd0:    return sel ? 6'd2  : 6'd0;
            4'd1:    return sel ? 6'd3  : 6'd1;
            4'd2:    return sel ? 6'd5  : 6'd1;
            4'd3:    return sel ? 6'd7  : 6'd2;
            4'd4:    return sel ? 6'd11 : 6'd3;
            4'd5:    return sel ? 6'd13 : 6'd5;
            4'd6:    return sel ? 6'd17 : 6'd8;
            4'd7:    return sel ? 6'd19 : 6'd13;
            4'd8:    return sel ? 6'd23 : 6'd21;
            4'd9:    return sel ? 6'd29 : 6'd34;
            4'd10:   return sel ? 6'd31 : 6'd55;
            default: return 6'd63;
        endcase
    endfunction

    function automatic logic [3:0] step_up(input logic [3:0] i);
        return (i == LAST) ? 4'd0 : i + 4'd1;
    endfunction

    function automatic logic [3:0] step_dn(input logic [3:0] i);
        return (i == 4'd0) ? LAST : i - 4'd1;
    endfunction

    state_t           state_q, state_d, cur_state;
    logic [3:0]       index_q, index_d;
    logic             dir_q, dir_d;
    logic [5:0]       prev_q, prev_d;
    logic             err_q, err_d;
    logic             dir_chg_q, dir_chg_d;
    logic [ERR_W-1:0] err_count_q, err_count_d;
    logic             fib_pri_q;

    logic             valid, up_hit, dn_hit;
    logic [3:0]       up_idx, dn_idx, idx_same, idx_opp;

    always_comb begin
        // A table switch abandons any lock silently; the current sample is judged as a fresh start.
        cur_state = (fibPri != fib_pri_q) ? IDLE : state_q;
        state_d   = cur_state;
        index_d   = index_q;
        dir_d     = dir_q;
        prev_d    = prev_q;
        err_d     = 1'b0;
        dir_chg_d = 1'b0;
        valid     = 1'b0;
        up_hit    = 1'b0;
        dn_hit    = 1'b0;
        up_idx    = '0;
        dn_idx    = '0;

        for (int i = 0; i < MOD; i++) begin
            if (term(fibPri, 4'(i)) == value) valid = 1'b1;
            if (term(fibPri, 4'(i)) == prev_q) begin
                if (term(fibPri, step_up(4'(i))) == value) begin
                    up_hit = 1'b1;
                    up_idx = step_up(4'(i));
                end
                if (term(fibPri, step_dn(4'(i))) == value) begin
                    dn_hit = 1'b1;
                    dn_idx = step_dn(4'(i));
                end
            end
        end

        idx_same = dir_q ? step_dn(index_q) : step_up(index_q);
        idx_opp  = dir_q ? step_up(index_q) : step_dn(index_q);

        if (en) begin
            case (cur_state)
                IDLE: begin
                    if (valid) begin
                        prev_d  = value;
                        state_d = ACQ;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                ACQ: begin
                    if (!valid) begin
                        state_d = IDLE;
                        err_d   = 1'b1;
                    end else if (up_hit && !dn_hit) begin
                        state_d = LOCKED;
                        dir_d   = 1'b0;
                        index_d = up_idx;
                    end else if (dn_hit && !up_hit) begin
                        state_d = LOCKED;
                        dir_d   = 1'b1;
                        index_d = dn_idx;
                    end else begin
                        // Both hit only on the Fibonacci 1->1 ambiguity, which is legal.
                        prev_d = value;
                        err_d  = !up_hit;
                    end
                end
                LOCKED: begin
                    if (value == term(fibPri, idx_same)) begin
                        index_d = idx_same;
                    end else if (value == term(fibPri, idx_opp)) begin
                        index_d   = idx_opp;
                        dir_d     = !dir_q;
                        dir_chg_d = 1'b1;
                    end else begin
                        err_d   = 1'b1;
                        prev_d  = value;
                        state_d = valid ? ACQ : IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        err_count_d = err_count_q;
        if (err_d && (err_count_q != '1)) err_count_d = err_count_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            index_q     <= '0;
            dir_q       <= 1'b0;
            prev_q      <= '0;
            err_q       <= 1'b0;
            dir_chg_q   <= 1'b0;
            err_count_q <= '0;
            fib_pri_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            index_q     <= index_d;
            dir_q       <= dir_d;
            prev_q      <= prev_d;
            err_q       <= err_d;
            dir_chg_q   <= dir_chg_d;
            err_count_q <= err_count_d;
            fib_pri_q   <= fibPri;
        end
    end

    assign index     = index_q;
    assign dir       = dir_q;
    assign locked    = (state_q == LOCKED);
    assign err       = err_q;
    assign dir_chg   = dir_chg_q;
    assign err_count = err_count_q;
endmodule

// File: tb/tb_seq_index_tracker.sv
// Randomized and directed scoreboard bench for seq_index_tracker against a table-driven reference model.
module tb_seq_index_tracker;
    logic       clk = 1'b0;
    logic       rst, en, fibPri;
    logic [5:0] value;
    logic [3:0] index;
    logic       dir, locked, err, dir_chg;
    logic [3:0] err_count;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        int idx;
        bit dir;
        bit lk;
        bit err;
        bit dc;
        int cnt;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    int fib_t[11]   = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34, 55};
    int prime_t[11] = '{2, 3, 5, 7, 11, 13, 17, 19, 23, 29, 31};

    // Reference model state: whether a previous term is held, whether locked, and the lock position.
    bit m_mode   = 1'b0;
    bit m_have   = 1'b0;
    bit m_locked = 1'b0;
    int m_prev   = 0;
    int m_idx    = 0;
    bit m_dir    = 1'b0;
    int m_cnt    = 0;

    int ph_prime_up[$] = '{2, 3, 5, 7, 11, 13, 17, 19, 23, 29, 31, 2, 3};
    int ph_reverse[$]  = '{5, 7, 11, 13, 11, 7, 11, 23, 29};
    int ph_fib_down[$] = '{3, 2, 1, 1, 0, 55, 1, 1, 2, 4};
    int ph_frozen[$]   = '{7, 33, 1, 55, 9};
    int ph_fib_lock[$] = '{0, 1, 1, 2};

    seq_index_tracker #(.ERR_W(4), .MOD(11)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .fibPri    (fibPri),
        .value     (value),
        .index     (index),
        .dir       (dir),
        .locked    (locked),
        .err       (err),
        .dir_chg   (dir_chg),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    function automatic int tv(input bit fp, input int i);
        return fp ? prime_t[i] : fib_t[i];
    endfunction

    function automatic bit in_table(input bit fp, input int v);
        for (int i = 0; i < 11; i++) if (tv(fp, i) == v) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_and_push(input bit e, input bit fp, input int v);
        exp_t x;
        bit   ev, dc, up, dn, ok;
        int   ui, di, nxt, opp;
        ev = 1'b0; dc = 1'b0; up = 1'b0; dn = 1'b0; ui = 0; di = 0;
        ok = in_table(fp, v);
        if (fp != m_mode) begin
            m_locked = 1'b0;
            m_have   = 1'b0;
        end
        m_mode = fp;
        if (e) begin
            if (m_locked) begin
                nxt = m_dir ? (m_idx + 10) % 11 : (m_idx + 1) % 11;
                opp = m_dir ? (m_idx + 1) % 11 : (m_idx + 10) % 11;
                if (v == tv(fp, nxt)) begin
                    m_idx = nxt;
                end else if (v == tv(fp, opp)) begin
                    m_idx = opp;
                    m_dir = ~m_dir;
                    dc    = 1'b1;
                end else begin
                    ev       = 1'b1;
                    m_locked = 1'b0;
                    m_have   = ok;
                    m_prev   = v;
                end
            end else if (!m_have) begin
                if (ok) begin
                    m_have = 1'b1;
                    m_prev = v;
                end else begin
                    ev = 1'b1;
                end
            end else if (!ok) begin
                ev     = 1'b1;
                m_have = 1'b0;
            end else begin
                for (int p = 0; p < 11; p++) begin
                    if (tv(fp, p) == m_prev) begin
                        if (tv(fp, (p + 1) % 11) == v) begin up = 1'b1; ui = (p + 1) % 11; end
                        if (tv(fp, (p + 10) % 11) == v) begin dn = 1'b1; di = (p + 10) % 11; end
                    end
                end
                if (up && !dn) begin
                    m_locked = 1'b1; m_dir = 1'b0; m_idx = ui;
                end else if (dn && !up) begin
                    m_locked = 1'b1; m_dir = 1'b1; m_idx = di;
                end else begin
                    m_prev = v;
                    ev     = !up;
                end
            end
        end
        if (ev && m_cnt < 15) m_cnt++;
        x.idx = m_idx; x.dir = m_dir; x.lk = m_locked; x.err = ev; x.dc = dc; x.cnt = m_cnt;
        sb.push_back(x);
    endtask

    task automatic drive(input bit e, input bit fp, input int v);
        @(negedge clk);
        en     = e;
        fibPri = fp;
        value  = 6'(v);
        model_and_push(e, fp, v);
    endtask

    task automatic run_seq(input bit e, input bit fp, input int vals[$]);
        foreach (vals[k]) drive(e, fp, vals[k]);
    endtask

    task automatic check_zero(input string name);
        n_chk++;
        if (index !== 4'd0 || dir !== 1'b0 || locked !== 1'b0 || err !== 1'b0 ||
            dir_chg !== 1'b0 || err_count !== 4'd0) begin
            n_fail++;
            $display("FAIL %s: got idx=%0d dir=%0d lk=%0d err=%0d dc=%0d cnt=%0d, expected all zero",
                     name, index, dir, locked, err, dir_chg, err_count);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            n_chk++;
            if (locked !== mon_e.lk || err !== mon_e.err || dir_chg !== mon_e.dc ||
                err_count !== 4'(mon_e.cnt) ||
                (mon_e.lk && (index !== 4'(mon_e.idx) || dir !== mon_e.dir))) begin
                n_fail++;
                $display("FAIL outputs t=%0t: got idx=%0d dir=%0d lk=%0d err=%0d dc=%0d cnt=%0d, expected idx=%0d dir=%0d lk=%0d err=%0d dc=%0d cnt=%0d",
                         $time, index, dir, locked, err, dir_chg, err_count,
                         mon_e.idx, mon_e.dir, mon_e.lk, mon_e.err, mon_e.dc, mon_e.cnt);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  ri, r, rv;
        bit  rd, rfp, re;
        ri = 0; rd = 1'b0; rfp = 1'b1;

        rst = 1'b1; en = 1'b0; fibPri = 1'b0; value = '0;
        #1 rst = 1'b0;
        #2 check_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        run_seq(1'b1, 1'b1, ph_prime_up);
        run_seq(1'b1, 1'b1, ph_reverse);
        run_seq(1'b1, 1'b0, ph_fib_down);
        run_seq(1'b0, 1'b0, ph_frozen);
        run_seq(1'b1, 1'b0, ph_fib_lock);
        drive(1'b1, 1'b1, 2);
        drive(1'b1, 1'b1, 3);
        repeat (20) drive(1'b1, 1'b1, 4);

        repeat (1500) begin
            r  = $urandom_range(0, 99);
            re = 1'b1;
            if (r < 5) re = 1'b0;
            else if (r < 8) rfp = ~rfp;
            else if (r >= 12 && r < 18) rd = ~rd;
            else if (r >= 18 && r < 21) ri = $urandom_range(0, 10);
            if (r >= 8 && r < 12) begin
                rv = $urandom_range(0, 63);
            end else begin
                ri = rd ? (ri + 10) % 11 : (ri + 1) % 11;
                rv = tv(rfp, ri);
            end
            drive(re, rfp, rv);
        end

        repeat (3) drive(1'b0, rfp, 0);
        for (int w = 0; w < 10 && sb.size() != 0; w++) @(posedge clk);
        #2;
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected responses left, required 0", sb.size());
        end

        @(negedge clk);
        #2 rst = 1'b0;
        #1 check_zero("async_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/seq_index_tracker.md
Name: seq_index_tracker

Overview:
- Receive end of the Fibonacci/prime sequence generator: samples the 6-bit term stream a mod-11 up/down index counter produces, recovers the index, and infers count direction.
- Locks onto a valid step sequence, flags any term that breaks it, and counts errors.
- Sits downstream of the generator's output mux as a checker/decoder and shares its en and fibPri controls.

Parameters:
ERR_W, 4, width of saturating error counter
MOD, 11, sequence length (indices 0..MOD-1); fixed tables below assume 11

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-low reset
en  input  1  sample enable; term sampled on rising clk when en=1
fibPri  input  1  table select: 0 = Fibonacci, 1 = prime
value  input  6  incoming term
index  output  4  recovered index 0..10, meaningful when locked=1
dir  output  1  0 = up, 1 = down; meaningful when locked=1
locked  output  1  tracker locked to the stream
err  output  1  one-cycle pulse: sequence violation or invalid term
dir_chg  output  1  one-cycle pulse: locked stream reversed direction
err_count  output  ERR_W  saturating count of err pulses

Behaviour:
- Tables, index 0..10:
  - Fib: 0,1,1,2,3,5,8,13,21,34,55.
  - Prime: 2,3,5,7,11,13,17,19,23,29,31.
  - A value not in the selected table is invalid.
  - Fib value 1 is ambiguous (index 1 or 2).
- Reset (rst=0, async): state=IDLE; index=0, dir=0, locked=0, err=0, dir_chg=0, err_count=0; stored previous term cleared.
- All outputs are registered and update on the same edge that samples value (1-cycle latency from sample to output). With en=0, state and index hold; err and dir_chg are 0.
- err and dir_chg are single-cycle pulses, deasserted on the next clk edge regardless of en.
- Step arithmetic is mod 11: up(10)=0, down(0)=10.
- States:
  - IDLE: on a sample:
    - valid → store term as prev, go ACQ.
    - invalid → err pulse, stay IDLE.
  - ACQ: on a sample, search all i with T(i)==prev:
    - T(i+1)==new is an up match; T(i-1)==new is a down match.
    - Only up matches → LOCKED, dir=0, index=i+1.
    - Only down matches → LOCKED, dir=1, index=i-1.
    - Both up and down match (Fib 1→1) → stay ACQ, prev=new, no err.
    - Neither matches, new valid → stay ACQ, prev=new, err pulse.
    - New invalid → IDLE, err pulse.
  - LOCKED: compute E_same = T(index stepped in dir) and E_opp = T(index stepped against dir). On a sample:
    - value==E_same → index steps in dir.
    - Else value==E_opp → index steps against dir, dir toggles, dir_chg pulse.
    - Else → err pulse, locked=0. New valid → ACQ with prev=value; invalid → IDLE.
    - E_same has priority; the two never coincide for either table.
- Counter reset mid-stream (term jumps to T(0) out of order) is a normal violation: err pulse, then reacquire.
- fibPri change: registered fibPri is compared each edge. On any change, state → IDLE and locked=0, with no err pulse. If en=1 on that edge, the sample is processed as IDLE's first sample under the new table.
- err_count increments on every err pulse and saturates at 2^ERR_W-1. Only rst clears it.
- Simultaneous rst deassertion and clk edge: the first sample is taken no earlier than the next rising edge.

Test Plan:
1. Prime up: fibPri=1, en=1, stream 2,3,5,7,…,31,2 → locked=1 after 2nd sample with index=1, dir=0; index wraps 10→0 on 31→2; err_count=0.
2. Fib down through ambiguity: fibPri=0, stream 3,2,1,1,0,55 → locks dir=1 at index 3 after "2"; then index 2,1,0,10; no err. Stream starting 1,1 up/down → stays ACQ, locks on next distinguishing term (1,1,2 → index 3, dir=0).
3. Reversal: prime locked up at index 5 (13), next 11 → dir=1, index=4, dir_chg=1 for exactly one cycle; next 7 → index 3.
4. Violation and reacquire: prime locked at index 4 (11), inject 23 then 29 → err pulse on 23, locked=0, err_count=1; relocks index 9, dir=0 after 29.
5. Invalid and enable: Fib stream term 4 → err, state IDLE. en=0 for 5 cycles with changing value → outputs frozen, no err.
6. Mode switch and reset: locked on Fib, toggle fibPri=1 with value 2 → locked=0, no err, prev=2. Saturation: drive 20 invalid terms → err_count=15. Async rst low mid-cycle → all outputs 0 immediately.
